count_down_timer: RTL
=====================

// Module: count_down_timer
// PURPOSE
//  Reconfigurable-module companion to the up-counter: loadable, pausable binary down-counter shown on 4 LEDs.
//  A free-running prescaler divides the 200MHz clock; each prescaler terminal count decrements the value.
//  It either wraps to the reload value or stops in DONE.
//  Sits in the same count RP slot and drives count_out to the LEDs; control inputs come from static-region buttons/regs.
// PARAMETERS
//  PRESCALE_W  25     prescaler width; terminal count = all ones (2^PRESCALE_W cycles per step)
//  CNT_W       4      counter/LED width
//  RELOAD_DEF  4'hF   reload value and count_out value after reset
// PORTS
//  clk        in   1       200MHz clock, single clock domain
//  rst        in   1       reset, synchronous, active-high
//  load       in   1       1-cycle strobe: capture load_val as reload value
//  load_val   in   CNT_W   value captured on load
//  start      in   1       1-cycle strobe: begin counting from IDLE/DONE
//  pause      in   1       level: hold count and prescaler while high
//  wrap_en    in   1       1: reload at zero and keep running; 0: stop in DONE
//  count_out  out  CNT_W   current count, registered, to LEDs
//  tick       out  1       1-cycle pulse, high in the cycle count_out takes a new value from counting
//  done       out  1       high while in DONE
//  running    out  1       high while in RUN
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, prescaler=0, reload_reg=RELOAD_DEF, count_out=RELOAD_DEF,
//   tick=0, done=0, running=0. Reset wins over every other input, including mid-RUN.
//  Priority per cycle: rst > load > start > pause.
//  load (any state): reload_reg<=load_val, count_out<=load_val, prescaler<=0, state<=IDLE, tick=0.
//  States:
//   IDLE : prescaler held at 0. start -> RUN (prescaler cleared, count_out unchanged).
//   RUN  : prescaler+1 each cycle, wraps naturally at 2^PRESCALE_W.
//          pause=1 -> PAUSE (prescaler frozen, no step that cycle).
//          On prescaler==all-ones (cycle N), at the next edge:
//          - count_out!=0 : count_out<=count_out-1; tick=1 in cycle N+1
//          - count_out==0 and wrap_en=1 : count_out<=reload_reg; tick=1; stay RUN
//          - count_out==0 and wrap_en=0 : state<=DONE; count_out stays 0; tick=0
//          start in RUN is ignored.
//   PAUSE: prescaler and count_out frozen. pause=0 -> RUN, resuming at the frozen prescaler value.
//          start is ignored in PAUSE.
//   DONE : done=1, count_out=0. start -> RUN with count_out<=reload_reg and prescaler<=0.
//  Outputs:
//   - All outputs are registered.
//   - running=1 exactly in RUN; done=1 exactly in DONE.
//   - tick is never high in two consecutive cycles (PRESCALE_W>=1).
//  Arithmetic: unsigned CNT_W-bit; decrement never underflows, because zero is handled by the wrap/stop rule.
//  Edge cases:
//   - Reload value 0 with wrap_en=1: count_out stays 0 and tick pulses every period.
//   - Reload value 0 with wrap_en=0: DONE after one full period.
//   - wrap_en is sampled only at the zero-step edge.
//   - load and pause in the same cycle: load wins, state=IDLE.
//   - pause high when start arrives in IDLE: go RUN, then PAUSE on the next cycle.
// STRUCTURE
//  Shared header count_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3
//   - RELOAD_DEF default
//  Sub-module count_prescaler (PRESCALE_W): inputs clk, rst, clr, en; output term.
//   - term is the combinational all-ones flag, qualified by en.
//  Top: FSM, reload_reg, count_out/tick/done/running registers.
// TESTING (bench with PRESCALE_W=3 -> one step per 8 RUN cycles)
//  1. rst 2 cycles -> count_out=4'hF, done=0, running=0, tick=0. start -> running=1; first tick 8 cycles later, count_out=4'hE.
//  2. load load_val=4'h2, wrap_en=0, start -> count 2,1,0, then DONE 8 cycles after reaching 0.
//     done=1, count_out=0; a further start reloads 4'h2.
//  3. load 4'h1, wrap_en=1, start -> sequence 1,0,1,0...; tick every 8 cycles, done never set.
//  4. pause=1 for 20 cycles in mid-period at count 4'hC -> count_out and tick frozen.
//     After release, the step lands 8 cycles minus the elapsed pre-pause count.
//  5. rst asserted mid-RUN at count 4'h7 -> next cycle state IDLE, count_out=RELOAD_DEF, running=0.
//  6. load and start in the same cycle while in DONE -> count_out=load_val, state IDLE, running=0.

Source files
------------

// File: rtl/count_down_timer_pkg.sv
// rtl/count_down_timer_pkg.sv - state encodings and defaults for the count-down timer
package count_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD_DEF_C = 4'hF;

endpackage

// File: rtl/count_down_timer_prescaler.sv
// rtl/count_down_timer_prescaler.sv - free-running prescaler with an enable-qualified terminal flag
module count_prescaler #(
    parameter int PRESCALE_W = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

    // Only a live (enabled) all-ones count is a step; a frozen one must not repeat it.
    assign term = en && (cnt == '1);

endmodule

// File: rtl/count_down_timer.sv
// rtl/count_down_timer.sv - loadable, pausable prescaled down-counter driving the LEDs
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int                PRESCALE_W = 25,
    parameter int                CNT_W      = 4,
    parameter logic [CNT_W-1:0]  RELOAD_DEF = CNT_W'(RELOAD_DEF_C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             wrap_en,
    output logic [CNT_W-1:0] count_out,
    output logic             tick,
    output logic             done,
    output logic             running
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] reload_reg;
    logic [CNT_W-1:0] count_next;
    logic             tick_next;
    logic             presc_clr;
    logic             presc_en;
    logic             term;

    // Prescaler controls kept outside the FSM block so term never feeds back into it.
    assign presc_en  = !load && (state == ST_RUN) && !pause;
    assign presc_clr = load || (state == ST_IDLE) || ((state == ST_DONE) && start);

    count_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .term (term)
    );

    always_comb begin
        state_next = state;
        count_next = count_out;
        tick_next  = 1'b0;
        if (load) begin
            state_next = ST_IDLE;
            count_next = load_val;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (term) begin
                        if (count_out != '0) begin
                            count_next = count_out - CNT_W'(1);
                            tick_next  = 1'b1;
                        end else if (wrap_en) begin
                            count_next = reload_reg;
                            tick_next  = 1'b1;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_next = ST_RUN;
                end
                ST_DONE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        count_next = reload_reg;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            reload_reg <= RELOAD_DEF;
            count_out  <= RELOAD_DEF;
            tick       <= 1'b0;
            done       <= 1'b0;
            running    <= 1'b0;
        end else begin
            state     <= state_next;
            count_out <= count_next;
            tick      <= tick_next;
            done      <= (state_next == ST_DONE);
            running   <= (state_next == ST_RUN);
            if (load) reload_reg <= load_val;
        end
    end

endmodule
